byte_mem_sequencer: RTL and testbench
=====================================

# byte_mem_sequencer

Load/store sequencer between the multi-cycle core and the byte-wide dual-port `Memory`. It performs every byte-, half- and word-sized access as a run of single-byte RAM cycles on port A and returns a completion pulse. Reads come back assembled, little-endian, and zero- or sign-extended. The core's hand-coded byte stepping for fetch, load and store moves into this block.

## Interface
- `ADDR_WIDTH`, 32: width of the request address.
- `RAM_ADDR_WIDTH`, 15: width of the RAM port-A address.
- `DATA_WIDTH`, 32: width of the request and response data.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `req_sext` in 1: sign-extend load data. Ignored for word accesses and stores.
- `req_addr` in ADDR_WIDTH: byte address. No alignment is required.
- `req_wdata` in DATA_WIDTH: store data, little-endian.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_WIDTH: extended load result. Holds its value until the next load completes.
- `ram_addr` out RAM_ADDR_WIDTH: RAM port-A address.
- `ram_data` out 8: RAM port-A write byte.
- `ram_wren` out 1: RAM port-A write enable.
- `ram_q` in 8: RAM port-A read data. It is registered: valid one cycle after the address is sampled.

## Operation
- Byte count n = 1, 2 or 4, taken from `req_size`.
- States:
  - IDLE: `req_ready` = 1.
  - READ: issues n addresses, then drains two more cycles.
  - WRITE: issues n write beats.
  - DONE: `rsp_valid` = 1; always returns to IDLE on the next edge.
- Accept: a request is taken on an edge where `req_valid` and `req_ready` are both 1.
  - On that edge the sequencer latches write, size, sext, address and wdata into internal registers.
  - It goes to READ or WRITE.
  - `req_ready` drops to 0 and stays 0 until IDLE is re-entered.
- Beat addresses: beat k (k = 0..n-1) uses `ram_addr` = (req_addr[RAM_ADDR_WIDTH-1:0] + k) mod 2^RAM_ADDR_WIDTH.
  - Upper address bits are discarded.
  - The address wraps at the top of RAM.
- READ:
  - `ram_wren` = 0 throughout.
  - Byte k is captured from `ram_q` into lane [8k+7:8k] two edges after beat k is issued.
  - After the last capture, lanes above n are filled with zeros, or with copies of bit 8n-1 when sext=1 and n<4.
  - The filled value is written to `rsp_rdata`, and the block enters DONE.
- WRITE:
  - Beat k drives `ram_wren` = 1 and `ram_data` = wdata[8k+7:8k].
  - After the last beat, `ram_wren` returns to 0 and the block enters DONE.
  - `rsp_rdata` is unchanged.
- Bytes outside the n-byte window are never read or written.
- While busy, `req_*` inputs are ignored. A request held across a busy period is accepted on the first IDLE edge.

## Timing
- Let E0 be the accept edge.
- Load:
  - Beat k address is driven after edge Ek.
  - Byte k is captured at edge E(k+2).
  - `rsp_valid` and the new `rsp_rdata` appear after edge E(n+1); latency is n+2 cycles.
  - Throughput: one load every n+3 cycles (byte 4, half 5, word 7).
- Store:
  - Beat k is driven after edge Ek. The RAM writes it at E(k+1).
  - `rsp_valid` appears after edge En; latency is n+1 cycles.
  - Throughput: one store every n+2 cycles.
- `rsp_valid` is high for exactly one cycle. IDLE follows, with `req_ready` = 1 in the next cycle.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `ram_addr`=0, `ram_data`=0, `ram_wren`=0, state IDLE.
- Reset asserted mid-operation:
  - Aborts immediately and asynchronously; `ram_wren` drops without waiting for an edge.
  - No response is issued.
  - Store bytes already written stay in RAM.
  - The first request is accepted at the first rising edge after `reset_n` deasserts.

## Structure
- The shared package holds the size encodings (SIZE_B, SIZE_H, SIZE_W) and the state enum (IDLE, READ, WRITE, DONE).
- The package also holds a size-to-byte-count function.
- There is no sub-module. Extension is a small combinational function in the package: extend(raw, size, sext).

## Test plan
- Load word at 0x0100, RAM[0x100..0x103] = 78 56 34 12 -> `rsp_valid` 6 cycles after accept, `rsp_rdata` = 0x12345678.
- Load byte sext=1 at 0x0200 = 0x80 -> `rsp_rdata` = 0xFFFFFF80. The same load with sext=0 -> 0x00000080, latency 3.
- Store half 0xBEEF at 0x7FFF -> RAM[0x7FFF] = 0xEF, RAM[0x0000] = 0xBE (wrap), RAM[0x0001] untouched, `rsp_valid` 3 cycles after accept.
- Back-to-back: store word 0xCAFEF00D at 0x40 with `req_valid` held, then load word at 0x40 -> second accept exactly 6 cycles after the first, load returns 0xCAFEF00D.
- Reset pulse during beat 2 of a word store -> `ram_wren` = 0 at once, no `rsp_valid`, bytes 0-1 written, bytes 2-3 unchanged, `req_ready` = 1.
- `req_addr` = 0xFFFF0010 load word -> RAM 0x0010..0x0013 accessed, and the `req_size` = 3 variant behaves identically.

Source files
------------

// File: rtl/byte_mem_sequencer_pkg.sv
// Shared types and helpers for the byte-stepping load/store sequencer:
// size encodings, FSM state encoding, byte counting and load extension.
package byte_mem_sequencer_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned RAM_ADDR_W = 15;
    localparam int unsigned DATA_W     = 32;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Encoding 3 is treated as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_B:  n = 3'd1;
            SIZE_H:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        sext);
        logic [31:0] r;
        case (size)
            SIZE_B:  r = {{24{sext & raw[7]}},  raw[7:0]};
            SIZE_H:  r = {{16{sext & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/byte_mem_sequencer_if.sv
// Core request/response handshake plus RAM port A, bundled for the sequencer.
// master = core and RAM side, slave = the sequencer itself.
interface byte_mem_sequencer_if #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH     = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [1:0]                req_size;
    logic                      req_sext;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]                ram_data;
    logic                      ram_wren;
    logic [7:0]                ram_q;

    modport master (
        output req_valid, req_write, req_size, req_sext, req_addr, req_wdata, ram_q,
        input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_data, ram_wren
    );

    modport slave (
        input  req_valid, req_write, req_size, req_sext, req_addr, req_wdata, ram_q,
        output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/byte_mem_sequencer.sv
// Turns byte/half/word loads and stores into runs of single-byte RAM port-A
// cycles; loads are reassembled little-endian and zero/sign-extended.
module byte_mem_sequencer
    import byte_mem_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_W,
    parameter int unsigned RAM_ADDR_WIDTH = RAM_ADDR_W,
    parameter int unsigned DATA_WIDTH     = DATA_W
) (
    input logic                 clock,
    input logic                 reset_n,
    byte_mem_sequencer_if.slave bus
);

    localparam int unsigned LOW_AW = (RAM_ADDR_WIDTH <= ADDR_WIDTH) ? RAM_ADDR_WIDTH : ADDR_WIDTH;

    state_e                    state_q, state_n;
    logic [2:0]                cnt_q, cnt_n;
    logic [1:0]                size_q, size_n;
    logic                      sext_q, sext_n;
    logic [RAM_ADDR_WIDTH-1:0] base_q, base_n;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_n;
    logic [DATA_WIDTH-1:0]     raw_q, raw_n;
    logic                      ready_q, ready_n;
    logic                      valid_q, valid_n;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_n;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [7:0]                data_q, data_n;
    logic                      wren_q, wren_n;
    logic [2:0]                nbytes_c;
    logic [2:0]                lane_c;

    assign nbytes_c = size_bytes(size_q);

    // cnt_q holds the index of the edge about to occur, counted from the accept edge.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        size_n  = size_q;
        sext_n  = sext_q;
        base_n  = base_q;
        wdata_n = wdata_q;
        raw_n   = raw_q;
        ready_n = ready_q;
        valid_n = valid_q;
        rdata_n = rdata_q;
        addr_n  = addr_q;
        data_n  = data_q;
        wren_n  = wren_q;
        lane_c  = cnt_q - 3'd2;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    size_n  = bus.req_size;
                    sext_n  = bus.req_sext;
                    base_n  = RAM_ADDR_WIDTH'(bus.req_addr[LOW_AW-1:0]);
                    addr_n  = RAM_ADDR_WIDTH'(bus.req_addr[LOW_AW-1:0]);
                    wdata_n = bus.req_wdata;
                    raw_n   = '0;
                    cnt_n   = 3'd1;
                    ready_n = 1'b0;
                    if (bus.req_write) begin
                        data_n  = bus.req_wdata[7:0];
                        wren_n  = 1'b1;
                        state_n = WRITE;
                    end else begin
                        state_n = READ;
                    end
                end
            end
            READ: begin
                cnt_n = cnt_q + 3'd1;
                if (cnt_q < nbytes_c) begin
                    addr_n = base_q + RAM_ADDR_WIDTH'(cnt_q);
                end
                // RAM output is registered, so byte k lands two edges after its address.
                if (cnt_q >= 3'd2) begin
                    raw_n[{lane_c[1:0], 3'b000} +: 8] = bus.ram_q;
                end
                if (cnt_q == nbytes_c + 3'd1) begin
                    rdata_n = DATA_WIDTH'(extend(32'(raw_n), size_q, sext_q));
                    valid_n = 1'b1;
                    state_n = DONE;
                end
            end
            WRITE: begin
                if (cnt_q < nbytes_c) begin
                    addr_n = base_q + RAM_ADDR_WIDTH'(cnt_q);
                    data_n = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    wren_n = 1'b1;
                    cnt_n  = cnt_q + 3'd1;
                end else begin
                    wren_n  = 1'b0;
                    valid_n = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                valid_n = 1'b0;
                ready_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= SIZE_B;
            sext_q  <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            raw_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            size_q  <= size_n;
            sext_q  <= sext_n;
            base_q  <= base_n;
            wdata_q <= wdata_n;
            raw_q   <= raw_n;
            ready_q <= ready_n;
            valid_q <= valid_n;
            rdata_q <= rdata_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            wren_q  <= wren_n;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_data  = data_q;
    assign bus.ram_wren  = wren_q;

endmodule

// File: tb/tb_byte_mem_sequencer.sv
// Directed bench for byte_mem_sequencer with a registered-output byte RAM model.
module tb_byte_mem_sequencer;
    import byte_mem_sequencer_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    byte_mem_sequencer_if #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(15), .DATA_WIDTH(32)) bus ();

    byte_mem_sequencer #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(15), .DATA_WIDTH(32)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [7:0] mem [0:32767];
    int         wren_edges = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(posedge clock) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_addr];
        if (bus.ram_wren) wren_edges <= wren_edges + 1;
    end

    // Issue one request, return latency in cycles (0 on timeout), response data,
    // and rsp_valid / req_ready one cycle after the response.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic tail_valid, output logic tail_ready);
        int guard;
        int j;
        @(negedge clock);
        bus.req_write = w;
        bus.req_size  = sz;
        bus.req_sext  = sx;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        j = 0;
        @(negedge clock);
        while (!bus.rsp_valid && j < 30) begin
            @(negedge clock);
            j++;
        end
        lat = bus.rsp_valid ? j + 1 : 0;
        rd  = bus.rsp_rdata;
        @(negedge clock);
        tail_valid = bus.rsp_valid;
        tail_ready = bus.req_ready;
    endtask

    task automatic test_reset();
        #1;
        if (bus.req_ready !== 1'b1) begin $display("FAIL reset_ready got %b want 1", bus.req_ready); n_bad++; end
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", bus.rsp_valid); n_bad++; end
        n_cmp++;
        if (bus.rsp_rdata !== 32'h0) begin $display("FAIL reset_rdata got %h want 0", bus.rsp_rdata); n_bad++; end
        n_cmp++;
        if (bus.ram_addr !== 15'h0) begin $display("FAIL reset_addr got %h want 0", bus.ram_addr); n_bad++; end
        n_cmp++;
        if (bus.ram_data !== 8'h0) begin $display("FAIL reset_data got %h want 0", bus.ram_data); n_bad++; end
        n_cmp++;
        if (bus.ram_wren !== 1'b0) begin $display("FAIL reset_wren got %b want 0", bus.ram_wren); n_bad++; end
        n_cmp++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_load_word();
        int lat; logic [31:0] rd; logic tv, tr; int w0;
        @(negedge clock);
        mem[15'h100] <= 8'h78; mem[15'h101] <= 8'h56; mem[15'h102] <= 8'h34; mem[15'h103] <= 8'h12;
        w0 = wren_edges;
        do_req(1'b0, SIZE_W, 1'b0, 32'h0000_0100, 32'h0, lat, rd, tv, tr);
        if (lat !== 6) begin $display("FAIL ldw_latency got %0d want 6", lat); n_bad++; end
        n_cmp++;
        if (rd !== 32'h1234_5678) begin $display("FAIL ldw_data got %h want 12345678", rd); n_bad++; end
        n_cmp++;
        if (tv !== 1'b0) begin $display("FAIL ldw_pulse got %b want 0", tv); n_bad++; end
        n_cmp++;
        if (tr !== 1'b1) begin $display("FAIL ldw_ready got %b want 1", tr); n_bad++; end
        n_cmp++;
        if (wren_edges !== w0) begin $display("FAIL ldw_nowrite got %0d want %0d", wren_edges, w0); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_load_byte_half();
        int lat; logic [31:0] rd; logic tv, tr;
        @(negedge clock);
        mem[15'h200] <= 8'h80; mem[15'h201] <= 8'h7F;
        mem[15'h210] <= 8'h34; mem[15'h211] <= 8'h92; mem[15'h212] <= 8'h55;
        do_req(1'b0, SIZE_B, 1'b1, 32'h0000_0200, 32'h0, lat, rd, tv, tr);
        if (lat !== 3) begin $display("FAIL ldb_sx_latency got %0d want 3", lat); n_bad++; end
        n_cmp++;
        if (rd !== 32'hFFFF_FF80) begin $display("FAIL ldb_sx_data got %h want ffffff80", rd); n_bad++; end
        n_cmp++;
        do_req(1'b0, SIZE_B, 1'b0, 32'h0000_0200, 32'h0, lat, rd, tv, tr);
        if (lat !== 3) begin $display("FAIL ldb_zx_latency got %0d want 3", lat); n_bad++; end
        n_cmp++;
        if (rd !== 32'h0000_0080) begin $display("FAIL ldb_zx_data got %h want 00000080", rd); n_bad++; end
        n_cmp++;
        do_req(1'b0, SIZE_H, 1'b1, 32'h0000_0210, 32'h0, lat, rd, tv, tr);
        if (lat !== 4) begin $display("FAIL ldh_sx_latency got %0d want 4", lat); n_bad++; end
        n_cmp++;
        if (rd !== 32'hFFFF_9234) begin $display("FAIL ldh_sx_data got %h want ffff9234", rd); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_store_wrap();
        int lat; logic [31:0] rd; logic tv, tr;
        @(negedge clock);
        mem[15'h7FFF] <= 8'h00; mem[15'h0000] <= 8'h00; mem[15'h0001] <= 8'h5A;
        do_req(1'b1, SIZE_H, 1'b0, 32'h0000_7FFF, 32'h1234_BEEF, lat, rd, tv, tr);
        if (lat !== 3) begin $display("FAIL sth_latency got %0d want 3", lat); n_bad++; end
        n_cmp++;
        if (mem[15'h7FFF] !== 8'hEF) begin $display("FAIL sth_byte0 got %h want ef", mem[15'h7FFF]); n_bad++; end
        n_cmp++;
        if (mem[15'h0000] !== 8'hBE) begin $display("FAIL sth_wrap got %h want be", mem[15'h0000]); n_bad++; end
        n_cmp++;
        if (mem[15'h0001] !== 8'h5A) begin $display("FAIL sth_untouched got %h want 5a", mem[15'h0001]); n_bad++; end
        n_cmp++;
        if (rd !== 32'hFFFF_9234) begin $display("FAIL sth_rdata_hold got %h want ffff9234", rd); n_bad++; end
        n_cmp++;
        if (tr !== 1'b1) begin $display("FAIL sth_ready got %b want 1", tr); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int acc; int j;
        @(negedge clock);
        bus.req_write = 1'b1; bus.req_size = SIZE_W; bus.req_sext = 1'b0;
        bus.req_addr = 32'h40; bus.req_wdata = 32'hCAFE_F00D; bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_write = 1'b0;
        bus.req_wdata = 32'h0;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus.req_ready) begin acc = k + 1; break; end
        end
        if (acc !== 6) begin $display("FAIL b2b_accept_gap got %0d want 6", acc); n_bad++; end
        n_cmp++;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        j = 0;
        @(negedge clock);
        while (!bus.rsp_valid && j < 30) begin @(negedge clock); j++; end
        if (j !== 5) begin $display("FAIL b2b_load_latency got %0d want 6", j + 1); n_bad++; end
        n_cmp++;
        if (bus.rsp_rdata !== 32'hCAFE_F00D) begin $display("FAIL b2b_data got %h want cafef00d", bus.rsp_rdata); n_bad++; end
        n_cmp++;
        if ({mem[15'h43], mem[15'h42], mem[15'h41], mem[15'h40]} !== 32'hCAFE_F00D) begin
            $display("FAIL b2b_mem got %h%h%h%h want cafef00d", mem[15'h43], mem[15'h42], mem[15'h41], mem[15'h40]);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_upper_addr();
        int lat; logic [31:0] rd; logic tv, tr;
        @(negedge clock);
        mem[15'h10] <= 8'h01; mem[15'h11] <= 8'h02; mem[15'h12] <= 8'h03; mem[15'h13] <= 8'h04;
        mem[15'h14] <= 8'hEE;
        do_req(1'b0, SIZE_W, 1'b1, 32'hFFFF_0010, 32'h0, lat, rd, tv, tr);
        if (lat !== 6) begin $display("FAIL upper_latency got %0d want 6", lat); n_bad++; end
        n_cmp++;
        if (rd !== 32'h0403_0201) begin $display("FAIL upper_data got %h want 04030201", rd); n_bad++; end
        n_cmp++;
        do_req(1'b0, 2'd3, 1'b1, 32'hFFFF_0010, 32'h0, lat, rd, tv, tr);
        if (lat !== 6) begin $display("FAIL size3_latency got %0d want 6", lat); n_bad++; end
        n_cmp++;
        if (rd !== 32'h0403_0201) begin $display("FAIL size3_data got %h want 04030201", rd); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_reset_mid_store();
        logic vseen; int j;
        @(negedge clock);
        mem[15'h300] <= 8'hAA; mem[15'h301] <= 8'hAA; mem[15'h302] <= 8'hAA; mem[15'h303] <= 8'hAA;
        bus.req_write = 1'b1; bus.req_size = SIZE_W; bus.req_sext = 1'b0;
        bus.req_addr = 32'h300; bus.req_wdata = 32'h1122_3344; bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        if (bus.ram_addr !== 15'h302 || bus.ram_wren !== 1'b1) begin
            $display("FAIL rst_beat2 got addr %h wren %b want 302 1", bus.ram_addr, bus.ram_wren); n_bad++;
        end
        n_cmp++;
        reset_n = 1'b0;
        #1;
        if (bus.ram_wren !== 1'b0) begin $display("FAIL rst_wren got %b want 0", bus.ram_wren); n_bad++; end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin $display("FAIL rst_ready got %b want 1", bus.req_ready); n_bad++; end
        n_cmp++;
        if (bus.rsp_rdata !== 32'h0) begin $display("FAIL rst_rdata got %h want 0", bus.rsp_rdata); n_bad++; end
        n_cmp++;
        bus.req_write = 1'b0; bus.req_size = SIZE_B; bus.req_sext = 1'b0;
        bus.req_addr = 32'h300; bus.req_valid = 1'b1;
        vseen = bus.rsp_valid;
        repeat (3) begin
            @(negedge clock);
            if (bus.rsp_valid) vseen = 1'b1;
        end
        if (vseen !== 1'b0) begin $display("FAIL rst_no_rsp got %b want 0", vseen); n_bad++; end
        n_cmp++;
        if ({mem[15'h303], mem[15'h302], mem[15'h301], mem[15'h300]} !== 32'hAAAA_3344) begin
            $display("FAIL rst_partial_mem got %h%h%h%h want aaaa3344", mem[15'h303], mem[15'h302], mem[15'h301], mem[15'h300]);
            n_bad++;
        end
        n_cmp++;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        if (bus.req_ready !== 1'b0) begin $display("FAIL rst_first_accept got ready %b want 0", bus.req_ready); n_bad++; end
        n_cmp++;
        bus.req_valid = 1'b0;
        j = 0;
        @(negedge clock);
        while (!bus.rsp_valid && j < 30) begin @(negedge clock); j++; end
        if (j !== 2) begin $display("FAIL rst_load_latency got %0d want 3", j + 1); n_bad++; end
        n_cmp++;
        if (bus.rsp_rdata !== 32'h0000_0044) begin $display("FAIL rst_load_data got %h want 00000044", bus.rsp_rdata); n_bad++; end
        n_cmp++;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = SIZE_B;
        bus.req_sext  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clock);
        test_reset();
        test_load_word();
        test_load_byte_half();
        test_store_wrap();
        test_back_to_back();
        test_upper_addr();
        test_reset_mid_store();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
